// File: rtl/mbtrain_handshake_engine_if.sv
// Sideband message bus between the MBTRAIN handshake engine and the
// sideband encoder/decoder.
//
// Signals (named from the engine's point of view):
//   i_decoded_sideband_message  partner message code, qualified by i_sideband_valid
//   i_sideband_valid            one-cycle receive strobe
//   i_busy                      sideband transmitter busy
//   i_falling_edge_busy         one-cycle pulse when the transmitter finishes a message
//   o_sideband_message          code to transmit, 0 when nothing is sent
//   o_valid                     one-cycle send strobe
//
// Modports:
//   master : the handshake engine
//   slave  : the sideband encoder/decoder side
interface mbtrain_handshake_engine_if #(
  parameter int MSG_W = 4
);
  logic [MSG_W-1:0] i_decoded_sideband_message;
  logic             i_sideband_valid;
  logic             i_busy;
  logic             i_falling_edge_busy;
  logic [MSG_W-1:0] o_sideband_message;
  logic             o_valid;

  modport master (
    input  i_decoded_sideband_message,
    input  i_sideband_valid,
    input  i_busy,
    input  i_falling_edge_busy,
    output o_sideband_message,
    output o_valid
  );

  modport slave (
    output i_decoded_sideband_message,
    output i_sideband_valid,
    output i_busy,
    output i_falling_edge_busy,
    input  o_sideband_message,
    input  o_valid
  );
endinterface

// File: rtl/mbtrain_handshake_engine.sv
// MBTRAIN request/response handshake engine.
// Runs N_PHASES request/response phases per side over one shared sideband
// port: a TX FSM sends requests (code 2p+1) and waits for responses (2p+2),
// an RX FSM waits for requests and sends responses. A registered arbiter
// grants the port only when the channel is free and the transmitter idle.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   i_en        substate enable; low returns everything to idle
//   sb          sideband bus (master modport)
//   o_phase     current TX phase index
//   o_test_ack  both sides have completed all phases
//   o_timeout   sticky watchdog error
//
// Optional feature: define MBTRAIN_HANDSHAKE_TIMEOUT_EN to add a watchdog
// that forces both FSMs into ERROR after TIMEOUT_CYCLES cycles without ack.
//
// TX state     | meaning
// TX_IDLE      | disabled
// TX_SEND_REQ  | request for tx phase pending on the arbiter
// TX_WAIT_RESP | request sent, waiting for response 2p+2
// TX_DONE      | all phases completed
// TX_ERROR     | watchdog expired (timeout build only)
//
// RX state     | meaning
// RX_IDLE      | disabled
// RX_WAIT_REQ  | waiting for request 2p+1
// RX_SEND_RESP | response for rx phase pending on the arbiter
// RX_DONE      | all phases completed
// RX_ERROR     | watchdog expired (timeout build only)
module mbtrain_handshake_engine #(
  parameter int MSG_W          = 4,
  parameter int N_PHASES       = 1,
  parameter int RX_PRIORITY    = 1,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  mbtrain_handshake_engine_if.master sb,
  output logic [2:0]                 o_phase,
  output logic                       o_test_ack,
  output logic                       o_timeout
);

  if (N_PHASES < 1 || N_PHASES > 7 || (2 * N_PHASES + 2) > (1 << MSG_W) ||
      TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("mbtrain_handshake_engine: illegal parameter combination");
  end

  localparam logic [2:0] LAST_PHASE = 3'(N_PHASES - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_SEND_REQ, TX_WAIT_RESP, TX_DONE
`ifdef MBTRAIN_HANDSHAKE_TIMEOUT_EN
    , TX_ERROR
`endif
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_WAIT_REQ, RX_SEND_RESP, RX_DONE
`ifdef MBTRAIN_HANDSHAKE_TIMEOUT_EN
    , RX_ERROR
`endif
  } rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [2:0]       tx_phase_q, tx_phase_d;
  logic [2:0]       rx_phase_q, rx_phase_d;
  logic             chan_free_q, chan_free_d;
  logic             valid_q, valid_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             ack_q, ack_d;
  logic             arb_go, grant_tx, grant_rx;
  logic             tx_hit, rx_hit;
  logic             to_fire;

  function automatic logic [MSG_W-1:0] req_code(input logic [2:0] p);
    return MSG_W'(2 * int'(p) + 1);
  endfunction

  function automatic logic [MSG_W-1:0] resp_code(input logic [2:0] p);
    return MSG_W'(2 * int'(p) + 2);
  endfunction

  assign tx_hit = sb.i_sideband_valid && (sb.i_decoded_sideband_message == resp_code(tx_phase_q));
  assign rx_hit = sb.i_sideband_valid && (sb.i_decoded_sideband_message == req_code(rx_phase_q));

`ifdef MBTRAIN_HANDSHAKE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;

  assign to_fire = i_en && !ack_q && !timeout_q && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin : p_watchdog
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q && i_en;
    if (!i_en) begin
      to_cnt_d = '0;
    end else if (to_fire) begin
      timeout_d = 1'b1;
    end else if (!ack_q && !timeout_q) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin : p_watchdog_reg
    if (rst) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign to_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin : p_state_reg
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      rx_state_q  <= RX_IDLE;
      tx_phase_q  <= '0;
      rx_phase_q  <= '0;
      chan_free_q <= 1'b1;
      valid_q     <= 1'b0;
      msg_q       <= '0;
      ack_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      rx_state_q  <= rx_state_d;
      tx_phase_q  <= tx_phase_d;
      rx_phase_q  <= rx_phase_d;
      chan_free_q <= chan_free_d;
      valid_q     <= valid_d;
      msg_q       <= msg_d;
      ack_q       <= ack_d;
    end
  end

  always_comb begin : p_next_state
    tx_state_d  = tx_state_q;
    rx_state_d  = rx_state_q;
    tx_phase_d  = tx_phase_q;
    rx_phase_d  = rx_phase_q;
    chan_free_d = chan_free_q;
    if (!i_en) begin
      tx_state_d  = TX_IDLE;
      rx_state_d  = RX_IDLE;
      tx_phase_d  = '0;
      rx_phase_d  = '0;
      chan_free_d = 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          tx_state_d = TX_SEND_REQ;
          tx_phase_d = '0;
        end
        TX_SEND_REQ: if (grant_tx) tx_state_d = TX_WAIT_RESP;
        TX_WAIT_RESP: begin
          if (tx_hit) begin
            // phase index holds at the last phase once DONE
            if (tx_phase_q == LAST_PHASE) begin
              tx_state_d = TX_DONE;
            end else begin
              tx_state_d = TX_SEND_REQ;
              tx_phase_d = tx_phase_q + 3'd1;
            end
          end
        end
        default: ;
      endcase

      case (rx_state_q)
        RX_IDLE: begin
          rx_state_d = RX_WAIT_REQ;
          rx_phase_d = '0;
        end
        RX_WAIT_REQ: if (rx_hit) rx_state_d = RX_SEND_RESP;
        RX_SEND_RESP: begin
          if (grant_rx) begin
            if (rx_phase_q == LAST_PHASE) begin
              rx_state_d = RX_DONE;
            end else begin
              rx_state_d = RX_WAIT_REQ;
              rx_phase_d = rx_phase_q + 3'd1;
            end
          end
        end
        default: ;
      endcase

      // A grant consumes the channel; a stale falling edge in the same
      // cycle must not re-free it.
      if (tx_state_q == TX_IDLE) begin
        chan_free_d = 1'b1;
      end else if (grant_tx || grant_rx) begin
        chan_free_d = 1'b0;
      end else if (sb.i_falling_edge_busy) begin
        chan_free_d = 1'b1;
      end

`ifdef MBTRAIN_HANDSHAKE_TIMEOUT_EN
      if (to_fire) begin
        tx_state_d = TX_ERROR;
        rx_state_d = RX_ERROR;
      end
`endif
    end
  end

  always_comb begin : p_outputs
    // grant looks only at the registered free flag, so a falling edge can
    // enable a grant no earlier than the following cycle
    arb_go   = i_en && chan_free_q && !sb.i_busy && !to_fire;
    grant_rx = arb_go && (rx_state_q == RX_SEND_RESP) &&
               ((RX_PRIORITY != 0) || (tx_state_q != TX_SEND_REQ));
    grant_tx = arb_go && (tx_state_q == TX_SEND_REQ) && !grant_rx;
    valid_d  = grant_tx || grant_rx;
    msg_d    = '0;
    if (grant_rx) begin
      msg_d = resp_code(rx_phase_q);
    end else if (grant_tx) begin
      msg_d = req_code(tx_phase_q);
    end
    ack_d = i_en && !to_fire && (tx_state_q == TX_DONE) && (rx_state_q == RX_DONE);
  end

  assign sb.o_valid            = valid_q;
  assign sb.o_sideband_message = msg_q;
  assign o_phase               = tx_phase_q;
  assign o_test_ack            = ack_q;

endmodule

// File: tb/tb_mbtrain_handshake_engine.sv
`timescale 1ns/1ps
module tb_mbtrain_handshake_engine;
  localparam int MSG_W = 4;
  localparam int NP    = 3;
  localparam int RXP   = 1;
  localparam int TC    = 50;
`ifdef MBTRAIN_HANDSHAKE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             en   = 1'b0;
  logic             sv   = 1'b0;
  logic [MSG_W-1:0] msg  = '0;
  logic             busy = 1'b0;
  logic             fall = 1'b0;
  logic [2:0]       o_phase;
  logic             o_test_ack;
  logic             o_timeout;

  int checks = 0;
  int errors = 0;

  mbtrain_handshake_engine_if #(.MSG_W(MSG_W)) sb_if ();
  assign sb_if.i_decoded_sideband_message = msg;
  assign sb_if.i_sideband_valid           = sv;
  assign sb_if.i_busy                     = busy;
  assign sb_if.i_falling_edge_busy        = fall;

  mbtrain_handshake_engine #(
    .MSG_W(MSG_W), .N_PHASES(NP), .RX_PRIORITY(RXP), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst), .i_en(en), .sb(sb_if),
    .o_phase(o_phase), .o_test_ack(o_test_ack), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model. Each side walks the code script 1..2N: TX sends the odd
  // codes and receives the even ones, RX the reverse. Progress counts the
  // script entries already completed, so the next code is always progress+1.
  // -1 = idle, 2N = done, -2 = watchdog error.
  int m_tx = -1, m_rx = -1, m_cnt = 0, e_msg = 0, e_phase = 0;
  bit m_free = 1'b1, m_to = 1'b0, e_valid = 1'b0, e_ack = 1'b0, m_started = 1'b0;

  always @(posedge clk) begin : model_p
    int ntx, nrx, nmsg;
    bit fire, txreq, rxrsp, can, grx, gtx, old_ack;
    if (rst || !en) begin
      m_started = m_started || rst;
      m_tx = -1; m_rx = -1; m_free = 1'b1; m_cnt = 0; m_to = 1'b0;
      e_valid = 1'b0; e_msg = 0; e_ack = 1'b0;
    end else begin
      old_ack = e_ack;
      fire  = TO_EN && !old_ack && !m_to && (m_cnt == TC - 1);
      txreq = (m_tx >= 0) && (m_tx < 2*NP) && (m_tx % 2 == 0);
      rxrsp = (m_rx >= 0) && (m_rx < 2*NP) && (m_rx % 2 == 1);
      can   = m_free && !busy && !fire;
      grx   = can && rxrsp && ((RXP != 0) || !txreq);
      gtx   = can && txreq && !grx;
      nmsg  = grx ? m_rx + 1 : (gtx ? m_tx + 1 : 0);
      ntx = m_tx;
      nrx = m_rx;
      if (m_tx == -1) ntx = 0;
      else if (gtx) ntx = m_tx + 1;
      else if (m_tx >= 0 && m_tx < 2*NP && m_tx % 2 == 1 && sv && int'(msg) == m_tx + 1) ntx = m_tx + 1;
      if (m_rx == -1) nrx = 0;
      else if (grx) nrx = m_rx + 1;
      else if (m_rx >= 0 && m_rx < 2*NP && m_rx % 2 == 0 && sv && int'(msg) == m_rx + 1) nrx = m_rx + 1;
      if (m_tx == -1) m_free = 1'b1;
      else if (gtx || grx) m_free = 1'b0;
      else if (fall) m_free = 1'b1;
      e_ack = (m_tx == 2*NP) && (m_rx == 2*NP) && !fire;
      if (fire) begin
        m_to = 1'b1; ntx = -2; nrx = -2;
      end else if (TO_EN && !old_ack && !m_to) begin
        m_cnt++;
      end
      e_valid = gtx || grx;
      e_msg   = nmsg;
      m_tx    = ntx;
      m_rx    = nrx;
    end
    if (m_tx >= 0) e_phase = (m_tx / 2 > NP - 1) ? NP - 1 : m_tx / 2;
    else if (m_tx == -1) e_phase = 0;
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("valid",   int'(sb_if.o_valid), int'(e_valid));
      chk("message", int'(sb_if.o_sideband_message), e_msg);
      chk("phase",   int'(o_phase), e_phase);
      chk("ack",     int'(o_test_ack), int'(e_ack));
      chk("timeout", int'(o_timeout), int'(m_to));
    end
  end

  task automatic step();
    @(negedge clk);
    sv   = 1'b0;
    fall = 1'b0;
  endtask

  task automatic wait_valid(input string nm, input int maxc, output int code);
    code = -1;
    for (int n = 0; n < maxc; n++) begin
      step();
      if (sb_if.o_valid) begin
        code = int'(sb_if.o_sideband_message);
        break;
      end
    end
    if (code < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: no o_valid within %0d cycles", nm, maxc);
    end
  endtask

  task automatic count_valid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (sb_if.o_valid) cnt++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int code, cnt;
    repeat (3) step();
    chk("reset_valid",   int'(sb_if.o_valid), 0);
    chk("reset_message", int'(sb_if.o_sideband_message), 0);
    chk("reset_phase",   int'(o_phase), 0);
    chk("reset_ack",     int'(o_test_ack), 0);
    chk("reset_timeout", int'(o_timeout), 0);
    rst = 1'b0;

    // TX walks requests 1,3,5 with an early bogus response 4 in phase 0
    en = 1'b1;
    for (int p = 0; p < NP; p++) begin
      wait_valid("tx_req", 10, code);
      chk("tx_req_code", code, 2*p + 1);
      chk("tx_req_phase", int'(o_phase), p);
      step(); fall = 1'b1;
      if (p == 0) begin
        step(); sv = 1'b1; msg = 4'd4;
      end
      step(); sv = 1'b1; msg = MSG_W'(2*p + 2);
    end
    repeat (4) step();
    chk("ack_tx_only", int'(o_test_ack), 0);

    // partner requests, RX answers 2,4,6
    for (int p = 0; p < NP; p++) begin
      step(); sv = 1'b1; msg = MSG_W'(2*p + 1);
      wait_valid("rx_resp", 10, code);
      chk("rx_resp_code", code, 2*p + 2);
      step(); fall = 1'b1;
    end
    repeat (3) step();
    chk("ack_both", int'(o_test_ack), 1);

    // disable clears ack; re-enable and drop i_en while waiting for response
    en = 1'b0;
    repeat (2) step();
    chk("ack_clear", int'(o_test_ack), 0);
    en = 1'b1;
    wait_valid("first_req", 10, code);
    chk("first_req_code", code, 1);
    step(); en = 1'b0;
    step();
    chk("dis_valid",   int'(sb_if.o_valid), 0);
    chk("dis_message", int'(sb_if.o_sideband_message), 0);
    chk("dis_phase",   int'(o_phase), 0);
    chk("dis_ack",     int'(o_test_ack), 0);

    // both pending under busy: RX response first, TX request after a falling edge
    busy = 1'b1;
    step(); en = 1'b1;
    step(); sv = 1'b1; msg = 4'd1;
    count_valid(10, cnt);
    chk("busy_no_valid", cnt, 0);
    busy = 1'b0;
    wait_valid("prio_first", 10, code);
    chk("prio_first_code", code, 2);
    count_valid(4, cnt);
    chk("no_valid_before_fall", cnt, 0);
    fall = 1'b1;
    wait_valid("tx_after_fall", 10, code);
    chk("tx_after_fall_code", code, 1);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      step();
      rst  = ($urandom_range(0, 399) == 0);
      en   = ($urandom_range(0, 199) != 0);
      busy = ($urandom_range(0, 3) == 0);
      fall = ($urandom_range(0, 2) == 0);
      sv   = ($urandom_range(0, 1) == 1);
      msg  = MSG_W'($urandom_range(0, 8));
    end
    step();
    rst = 1'b0; en = 1'b1; busy = 1'b0; msg = '0;

`ifdef MBTRAIN_HANDSHAKE_TIMEOUT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (40) step();
    chk("timeout_early", int'(o_timeout), 0);
    repeat (20) step();
    chk("timeout_set", int'(o_timeout), 1);
    count_valid(10, cnt);
    chk("timeout_no_valid", cnt, 0);
    chk("timeout_sticky", int'(o_timeout), 1);
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mbtrain_handshake_engine.md
# mbtrain_handshake_engine

Parametrised successor to the single-phase MBTRAIN self-cal wrapper. It runs N back-to-back request/response phases of an MBTRAIN substate over the sideband, with one TX (requester) FSM and one RX (responder) FSM. Both FSMs share one sideband message port through a registered arbiter that honours busy and falling-edge pacing. It adds an optional timeout watchdog. It sits between the MBTRAIN substate sequencer and the sideband encoder/decoder.

## Interface
- MSG_W, 4: sideband message code width; must satisfy 2*N_PHASES+2 <= 2^MSG_W.
- N_PHASES, 1: number of req/resp phases per side; valid range 1..7.
- RX_PRIORITY, 1: 1 = a pending RX response beats a pending TX request; 0 = TX wins.
- TIMEOUT_CYCLES, 1000: watchdog limit. Used only when the macro is defined.
- clk input 1: single clock, rising edge.
- rst input 1: synchronous, active-high reset.
- i_en input 1: substate enable. Low returns the block to idle.
- i_decoded_sideband_message input MSG_W: decoded partner message; qualified by i_sideband_valid.
- i_sideband_valid input 1: one-cycle strobe for a received message.
- i_busy input 1: sideband transmitter busy.
- i_falling_edge_busy input 1: one-cycle pulse when the transmitter finishes a message.
- o_sideband_message output MSG_W: code to transmit. 0 when idle.
- o_valid output 1: one-cycle send strobe.
- o_phase output 3: current TX phase index.
- o_test_ack output 1: both sides completed all phases.
- o_timeout output 1: sticky watchdog error.

## Operation
- Code map: phase p (0-based) request = 2p+1, response = 2p+2. Code 0 means none. Any other code is ignored.
- TX FSM states: IDLE → SEND_REQ(p) → WAIT_RESP(p) → next SEND_REQ(p+1), or DONE after the last phase.
  - SEND_REQ leaves when its request is granted.
  - WAIT_RESP leaves when i_sideband_valid is high and the message equals 2p+2.
- RX FSM states: IDLE → WAIT_REQ(p) → SEND_RESP(p) → next WAIT_REQ(p+1), or DONE.
  - WAIT_REQ accepts only the code 2p+1.
  - Out-of-order or repeated codes are ignored.
- A phase counter of 3 bits per side wraps to DONE; the count never wraps to 0.
- Arbiter: a channel_free flag is set at reset and on entry from IDLE.
  - It clears when o_valid issues and sets again on i_falling_edge_busy.
  - A grant requires channel_free=1, i_busy=0, and a pending SEND state. Tie-break follows RX_PRIORITY.
  - The loser stays pending and retries after the next falling edge.
- o_test_ack = TX DONE && RX DONE. It holds until i_en falls.
- i_en low at any edge: both FSMs go to IDLE, counters clear, o_valid=0, o_sideband_message=0, and o_test_ack=0. o_timeout is also cleared.
- Receive and send are independent. A message that arrives while the block's own send is pending is still consumed in that cycle.

## Timing
- Reset values: o_sideband_message=0, o_valid=0, o_phase=0, o_test_ack=0, o_timeout=0, channel_free=1.
- Edge E0 samples i_en=1: the FSMs enter SEND_REQ(0) and WAIT_REQ(0). o_valid can pulse at E1 at the earliest.
- A matching request received at edge E moves RX to SEND_RESP at E. The response o_valid can pulse at E+1 at the earliest.
- o_valid is exactly 1 cycle wide. o_sideband_message is valid in the same cycle and returns to 0 the cycle after.
- A falling-edge pulse and a new grant may coincide. The grant is taken in the cycle after the flag sets, never in the same cycle.
- o_test_ack rises 1 cycle after the later of the two DONE entries.
- rst asserted mid-handshake: all state returns to reset values at that edge, with no further o_valid.

## Configuration
- MBTRAIN_HANDSHAKE_TIMEOUT_EN defined:
  - A counter increments every cycle while i_en=1 and o_test_ack=0.
  - When it reaches TIMEOUT_CYCLES-1, o_timeout sets at the next edge and both FSMs enter ERROR.
  - In ERROR, o_valid is held at 0 and o_test_ack stays 0. The block leaves ERROR only on i_en low or rst.
- Macro undefined: no counter and no ERROR state. o_timeout is constant 0.

## Test plan
- N_PHASES=1, partner answers instantly → TX sends 1 and RX sends 2 on separate o_valid pulses. o_test_ack=1 after both receive 2 and 1.
- N_PHASES=3 → TX sends codes 1, 3, 5 in order with o_phase stepping 0, 1, 2. An early response code 4 while waiting for 2 is ignored.
- TX and RX pending together, RX_PRIORITY=1 → code 2 goes first. Code 1 goes only after an i_falling_edge_busy pulse and with i_busy=0.
- i_busy held high for 10 cycles → no o_valid during those cycles. A single pulse follows after busy drops and the falling edge arrives.
- i_en dropped in WAIT_RESP → the next cycle shows all outputs 0. Re-enabling restarts with code 1.
- Macro on, TIMEOUT_CYCLES=50, no partner traffic → o_timeout=1 at cycle 50 and stays high, with no further o_valid. Macro off → o_timeout stays 0.
